zigbee_cordic_arbiter: RTL and testbench

Shares one phase CORDIC (fixed latency, no backpressure) between NUM_REQ I/Q requesters, for example the two demodulator branches. Arbitration is round-robin with a valid/ready handshake on the request side. Each issued sample carries a tag down a shift pipeline matched to the CORDIC latency, so every returned angle is routed to the requester that issued it. Sits between the baseband sample sources and the CORDIC instance, and drives the CORDIC's ibb/qbb/iValid inputs directly.

---
 rtl/zigbee_cordic_pkg.sv | 27 ++
 rtl/zigbee_cordic_arbiter_rr.sv | 77 +++++++
 rtl/zigbee_cordic_arbiter.sv | 146 ++++++++++++++
 tb/tb_zigbee_cordic_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zigbee_cordic_pkg.sv
// ============================================================================
// Module  : zigbee_cordic_pkg
// Purpose : Shared constants and tag types for the CORDIC request arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package zigbee_cordic_pkg;

    // Default configuration of the shared phase CORDIC and its two requesters.
    localparam int CORDIC_LAT = 3;
    localparam int IQ_SIZE    = 5;
    localparam int W_SIZE     = 6;
    localparam int NUM_REQ    = 2;

    // Requester index carried alongside each sample through the CORDIC.
    typedef logic [$clog2(NUM_REQ)-1:0] tag_t;

    // One stage of the tag shift pipeline.
    typedef struct packed {
        logic valid;
        tag_t tag;
    } tag_stage_t;

endpackage

`default_nettype wire

// File: rtl/zigbee_cordic_arbiter_rr.sv
// ============================================================================
// Module  : zigbee_rr_arbiter
// Purpose : Round-robin grant over NUM_REQ requesters. The search starts at
//           the pointer and wraps upward; the pointer moves to the requester
//           after the one that transferred.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module zigbee_rr_arbiter #(
    parameter int NUM_REQ = zigbee_cordic_pkg::NUM_REQ,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arb_en,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               gnt_fire_o,
    output logic [PTR_W-1:0]   gnt_idx_o
);
    import zigbee_cordic_pkg::*;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             found_w;
    logic [PTR_W-1:0] idx_w;
    logic [PTR_W-1:0] cand_w;
    int               cand;

    // Find the first valid requester at or after the pointer, with wrap.
    always_comb begin
        found_w = 1'b0;
        idx_w   = '0;
        cand    = 0;
        cand_w  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand   = (int'(ptr_q) + i) % NUM_REQ;
            cand_w = PTR_W'(cand);
            if (!found_w && req_valid[cand_w]) begin
                found_w = 1'b1;
                idx_w   = cand_w;
            end
        end
    end

    // One-hot ready, suppressed entirely while grants are disabled.
    always_comb begin
        req_ready = '0;
        if (found_w && arb_en) begin
            req_ready[idx_w] = 1'b1;
        end
    end

    assign gnt_fire_o = |(req_valid & req_ready);
    assign gnt_idx_o  = idx_w;

    // Next pointer: one past the requester that transferred, else unchanged.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_fire_o) begin
            ptr_d = (idx_w == PTR_W'(NUM_REQ - 1)) ? '0 : idx_w + PTR_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/zigbee_cordic_arbiter.sv
// ============================================================================
// Module  : zigbee_cordic_arbiter
// Purpose : Shares one fixed-latency phase CORDIC between NUM_REQ I/Q
//           requesters. Each issued sample's requester index travels down a
//           tag pipeline matched to the CORDIC latency so every returned
//           angle is routed back to its issuer.
// Options : ZIGBEE_CORDIC_ARB_ALIGN_CHECK_EN builds a sticky err_align flag
//           that fires when cor_ovalid disagrees with the last tag stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module zigbee_cordic_arbiter #(
    parameter int NUM_REQ    = zigbee_cordic_pkg::NUM_REQ,
    parameter int IQ_SIZE    = zigbee_cordic_pkg::IQ_SIZE,
    parameter int W_SIZE     = zigbee_cordic_pkg::W_SIZE,
    parameter int CORDIC_LAT = zigbee_cordic_pkg::CORDIC_LAT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arb_en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*IQ_SIZE-1:0] req_ibb,
    input  logic [NUM_REQ*IQ_SIZE-1:0] req_qbb,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [IQ_SIZE-1:0]         cor_ibb,
    output logic [IQ_SIZE-1:0]         cor_qbb,
    output logic                       cor_valid,
    input  logic [W_SIZE-1:0]          cor_wout,
    input  logic                       cor_ovalid,
    output logic [W_SIZE-1:0]          res_w,
    output logic [NUM_REQ-1:0]         res_valid,
    output logic                       err_align
);
    import zigbee_cordic_pkg::*;

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Stage 0 sits beside cor_valid; the last stage lines up with cor_ovalid.
    localparam int DEPTH = CORDIC_LAT + 1;

    logic               gnt_fire;
    logic [TAG_W-1:0]   gnt_idx;
    logic [IQ_SIZE-1:0] gnt_i_w;
    logic [IQ_SIZE-1:0] gnt_q_w;

    logic [IQ_SIZE-1:0] cor_ibb_q;
    logic [IQ_SIZE-1:0] cor_qbb_q;
    logic               cor_valid_q;

    logic [DEPTH-1:0]   stg_v_q;
    logic [TAG_W-1:0]   stg_t_q [DEPTH];
    logic               last_v_w;
    logic [TAG_W-1:0]   last_t_w;

    logic [W_SIZE-1:0]  res_w_q;
    logic [NUM_REQ-1:0] res_valid_q;

    zigbee_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (TAG_W)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .arb_en     (arb_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .gnt_fire_o (gnt_fire),
        .gnt_idx_o  (gnt_idx)
    );

    assign gnt_i_w = req_ibb[int'(gnt_idx) * IQ_SIZE +: IQ_SIZE];
    assign gnt_q_w = req_qbb[int'(gnt_idx) * IQ_SIZE +: IQ_SIZE];

    // Issue registers: present the granted sample to the CORDIC for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cor_ibb_q   <= '0;
            cor_qbb_q   <= '0;
            cor_valid_q <= 1'b0;
        end else begin
            cor_valid_q <= gnt_fire;
            if (gnt_fire) begin
                cor_ibb_q <= gnt_i_w;
                cor_qbb_q <= gnt_q_w;
            end
        end
    end

    // Tag pipeline: shifts every cycle since the CORDIC never stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_v_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                stg_t_q[s] <= '0;
            end
        end else begin
            stg_v_q    <= {stg_v_q[DEPTH-2:0], gnt_fire};
            stg_t_q[0] <= gnt_idx;
            for (int s = 1; s < DEPTH; s++) begin
                stg_t_q[s] <= stg_t_q[s-1];
            end
        end
    end

    assign last_v_w = stg_v_q[DEPTH-1];
    assign last_t_w = stg_t_q[DEPTH-1];

    // Result routing: a returned angle with no matching tag is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_w_q     <= '0;
            res_valid_q <= '0;
        end else if (cor_ovalid && last_v_w) begin
            res_w_q     <= cor_wout;
            res_valid_q <= NUM_REQ'(1) << last_t_w;
        end else begin
            res_valid_q <= '0;
        end
    end

`ifdef ZIGBEE_CORDIC_ARB_ALIGN_CHECK_EN
    logic err_align_q;

    // Sticky flag: CORDIC output strobe and tag pipeline disagree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_align_q <= 1'b0;
        end else if (cor_ovalid != last_v_w) begin
            err_align_q <= 1'b1;
        end
    end

    assign err_align = err_align_q;
`else
    assign err_align = 1'b0;
`endif

    assign cor_ibb   = cor_ibb_q;
    assign cor_qbb   = cor_qbb_q;
    assign cor_valid = cor_valid_q;
    assign res_w     = res_w_q;
    assign res_valid = res_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_zigbee_cordic_arbiter.sv
// ============================================================================
// Module  : tb_zigbee_cordic_arbiter
// Purpose : Directed self-checking bench for zigbee_cordic_arbiter with a
//           latency-3 CORDIC stand-in whose angle is sext(I) - sext(Q).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zigbee_cordic_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       arb_en;
    logic [1:0] req_valid;
    logic [9:0] req_ibb;
    logic [9:0] req_qbb;
    logic [1:0] req_ready;
    logic [4:0] cor_ibb;
    logic [4:0] cor_qbb;
    logic       cor_valid;
    logic [5:0] cor_wout;
    logic       cor_ovalid;
    logic [5:0] res_w;
    logic [1:0] res_valid;
    logic       err_align;

    int n_cmp = 0;
    int n_err = 0;

    // CORDIC stand-in state and spurious-strobe injection.
    logic [2:0] m_v;
    logic [5:0] m_w0, m_w1, m_w2;
    logic       inj;
    logic [5:0] inj_w;

`ifdef ZIGBEE_CORDIC_ARB_ALIGN_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    zigbee_cordic_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .arb_en     (arb_en),
        .req_valid  (req_valid),
        .req_ibb    (req_ibb),
        .req_qbb    (req_qbb),
        .req_ready  (req_ready),
        .cor_ibb    (cor_ibb),
        .cor_qbb    (cor_qbb),
        .cor_valid  (cor_valid),
        .cor_wout   (cor_wout),
        .cor_ovalid (cor_ovalid),
        .res_w      (res_w),
        .res_valid  (res_valid),
        .err_align  (err_align)
    );

    function automatic logic [5:0] angle(input logic [4:0] i, input logic [4:0] q);
        return {i[4], i} - {q[4], q};
    endfunction

    // Latency 3: sampled at edge E, oValid visible after edge E+2.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_v  <= '0;
            m_w0 <= '0;
            m_w1 <= '0;
            m_w2 <= '0;
        end else begin
            m_v  <= {m_v[1:0], cor_valid};
            m_w0 <= angle(cor_ibb, cor_qbb);
            m_w1 <= m_w0;
            m_w2 <= m_w1;
        end
    end

    assign cor_ovalid = m_v[2] | inj;
    assign cor_wout   = inj ? inj_w : m_w2;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; arb_en = 1'b0; req_valid = '0; req_ibb = '0; req_qbb = '0;
        inj = 1'b0; inj_w = '0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", req_ready); end
        n_cmp++; if (cor_valid !== 1'b0) begin n_err++; $display("FAIL reset_cor_valid got %b want 0", cor_valid); end
        n_cmp++; if (cor_ibb !== 5'd0 || cor_qbb !== 5'd0) begin n_err++; $display("FAIL reset_cor_iq got %h/%h want 0/0", cor_ibb, cor_qbb); end
        n_cmp++; if (res_valid !== 2'b00 || res_w !== 6'd0) begin n_err++; $display("FAIL reset_res got %b/%h want 00/0", res_valid, res_w); end
        n_cmp++; if (err_align !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err_align); end
        cyc();
        reset = 1'b0; arb_en = 1'b1;
    endtask

    task automatic test_single();
        logic [1:0] exp_rv;
        for (int c = 0; c < 7; c++) begin
            cyc();
            req_valid = (c == 0) ? 2'b01 : 2'b00;
            req_ibb   = (c == 0) ? {5'd0, 5'd5} : 10'd0;
            req_qbb   = '0;
            #1;
            if (c == 0) begin
                n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got %b want 01", req_ready); end
            end
            if (c == 1) begin
                n_cmp++; if (cor_valid !== 1'b1 || cor_ibb !== 5'd5 || cor_qbb !== 5'd0) begin
                    n_err++; $display("FAIL single_issue got v=%b i=%h q=%h want v=1 i=05 q=00", cor_valid, cor_ibb, cor_qbb); end
            end
            exp_rv = (c == 5) ? 2'b01 : 2'b00;
            n_cmp++; if (res_valid !== exp_rv) begin n_err++; $display("FAIL single_res_valid c=%0d got %b want %b", c, res_valid, exp_rv); end
            if (c >= 5) begin
                n_cmp++; if (res_w !== 6'd5) begin n_err++; $display("FAIL single_res_w c=%0d got %h want 05", c, res_w); end
            end
        end
    endtask

    task automatic test_req1_only();
        logic [1:0] exp_rv;
        for (int c = 0; c < 16; c++) begin
            cyc();
            req_valid = (c < 10) ? 2'b10 : 2'b00;
            req_ibb   = {5'(c + 1), 5'h1F};
            req_qbb   = {5'd2, 5'h0A};
            #1;
            n_cmp++; if (req_ready !== ((c < 10) ? 2'b10 : 2'b00)) begin
                n_err++; $display("FAIL r1_ready c=%0d got %b", c, req_ready); end
            if (c >= 1 && c <= 10) begin
                n_cmp++; if (cor_valid !== 1'b1 || cor_ibb !== 5'(c)) begin
                    n_err++; $display("FAIL r1_issue c=%0d got v=%b i=%h want v=1 i=%h", c, cor_valid, cor_ibb, 5'(c)); end
            end
            exp_rv = (c >= 5 && c < 15) ? 2'b10 : 2'b00;
            n_cmp++; if (res_valid !== exp_rv) begin n_err++; $display("FAIL r1_res_valid c=%0d got %b want %b", c, res_valid, exp_rv); end
            if (c >= 5 && c < 15) begin
                n_cmp++; if (res_w !== 6'(c - 6)) begin n_err++; $display("FAIL r1_res_w c=%0d got %h want %h", c, res_w, 6'(c - 6)); end
            end
        end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_rv;
        logic [5:0] exp_w;
        int src;
        for (int c = 0; c < 14; c++) begin
            cyc();
            req_valid = (c < 8) ? 2'b11 : 2'b00;
            req_ibb   = {5'(c + 8), 5'(c)};
            req_qbb   = {5'd0, 5'd1};
            #1;
            if (c < 8) begin
                n_cmp++; if (req_ready !== ((c % 2 == 1) ? 2'b10 : 2'b01)) begin
                    n_err++; $display("FAIL alt_ready c=%0d got %b", c, req_ready); end
            end
            src    = c - 5;
            exp_rv = (c >= 5 && c < 13) ? ((src % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            n_cmp++; if (res_valid !== exp_rv) begin n_err++; $display("FAIL alt_res_valid c=%0d got %b want %b", c, res_valid, exp_rv); end
            if (c >= 5 && c < 13) begin
                exp_w = (src % 2 == 1) ? 6'(src + 8) : 6'(src - 1);
                n_cmp++; if (res_w !== exp_w) begin n_err++; $display("FAIL alt_res_w c=%0d got %h want %h", c, res_w, exp_w); end
            end
        end
        n_cmp++; if (err_align !== 1'b0) begin n_err++; $display("FAIL alt_err got %b want 0", err_align); end
    endtask

    task automatic test_arb_drop();
        logic [1:0] exp_rdy;
        logic [1:0] exp_rv;
        logic [5:0] exp_w;
        int pulses = 0;
        for (int c = 0; c < 16; c++) begin
            cyc();
            arb_en    = (c < 3);
            req_valid = (c < 8) ? 2'b11 : 2'b00;
            req_ibb   = {5'(c), 5'(c + 4)};
            req_qbb   = {5'd3, 5'd0};
            #1;
            case (c)
                0, 2:    exp_rdy = 2'b01;
                1:       exp_rdy = 2'b10;
                default: exp_rdy = 2'b00;
            endcase
            n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL drop_ready c=%0d got %b want %b", c, req_ready, exp_rdy); end
            case (c)
                5:       begin exp_rv = 2'b01; exp_w = 6'd4;  end
                6:       begin exp_rv = 2'b10; exp_w = 6'h3E; end
                7:       begin exp_rv = 2'b01; exp_w = 6'd6;  end
                default: begin exp_rv = 2'b00; exp_w = 6'd0;  end
            endcase
            n_cmp++; if (res_valid !== exp_rv) begin n_err++; $display("FAIL drop_res_valid c=%0d got %b want %b", c, res_valid, exp_rv); end
            if (exp_rv != 2'b00) begin
                n_cmp++; if (res_w !== exp_w) begin n_err++; $display("FAIL drop_res_w c=%0d got %h want %h", c, res_w, exp_w); end
            end
            if (c >= 3 && res_valid != 2'b00) pulses++;
        end
        n_cmp++; if (pulses != 3) begin n_err++; $display("FAIL drop_pulses got %0d want 3", pulses); end
        arb_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 18; c++) begin
            cyc();
            reset     = (c == 2 || c == 3);
            req_valid = (c < 2 || c == 11) ? 2'b11 : 2'b00;
            req_ibb   = (c == 11) ? {5'd9, 5'd7} : {5'd1, 5'd2};
            req_qbb   = (c == 11) ? {5'd0, 5'd2} : {5'd0, 5'd0};
            #1;
            if (c == 0) begin
                n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL rmid_pre_ready got %b want 10", req_ready); end
            end
            if (c == 2) begin
                n_cmp++; if (cor_valid !== 1'b0 || cor_ibb !== 5'd0 || cor_qbb !== 5'd0) begin
                    n_err++; $display("FAIL rmid_cor got v=%b i=%h q=%h want all 0", cor_valid, cor_ibb, cor_qbb); end
                n_cmp++; if (res_w !== 6'd0 || req_ready !== 2'b00 || err_align !== 1'b0) begin
                    n_err++; $display("FAIL rmid_out got w=%h rdy=%b err=%b want 0", res_w, req_ready, err_align); end
            end
            if (c >= 2 && c <= 10) begin
                n_cmp++; if (res_valid !== 2'b00 || cor_valid !== 1'b0) begin
                    n_err++; $display("FAIL rmid_idle c=%0d got rv=%b cv=%b want 00/0", c, res_valid, cor_valid); end
            end
            if (c == 11) begin
                n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rmid_next_ready got %b want 01", req_ready); end
            end
            if (c == 12) begin
                n_cmp++; if (cor_ibb !== 5'd7) begin n_err++; $display("FAIL rmid_next_issue got %h want 07", cor_ibb); end
            end
            if (c == 16) begin
                n_cmp++; if (res_valid !== 2'b01 || res_w !== 6'd5) begin
                    n_err++; $display("FAIL rmid_next_res got %b/%h want 01/05", res_valid, res_w); end
            end
        end
    endtask

    task automatic test_align();
        for (int c = 0; c < 5; c++) begin
            cyc();
            inj   = (c == 0);
            inj_w = 6'h15;
            #1;
            if (c >= 1) begin
                n_cmp++; if (res_valid !== 2'b00) begin n_err++; $display("FAIL align_res_valid c=%0d got %b want 00", c, res_valid); end
                n_cmp++; if (err_align !== EXP_ERR) begin n_err++; $display("FAIL align_err c=%0d got %b want %b", c, err_align, EXP_ERR); end
            end
        end
        reset = 1'b1;
        #2;
        n_cmp++; if (err_align !== 1'b0) begin n_err++; $display("FAIL align_err_cleared got %b want 0", err_align); end
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_req1_only();
        test_alternate();
        test_arb_drop();
        test_reset_mid();
        test_align();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
